// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: frame-level command sequencer between the SPI slave core
// and the internal register bus. The first word of each chip-select frame
// is a command; the following words are auto-incrementing register reads
// or writes, one bus transaction per SPI word. Sticky status flags report
// framing and bus errors and are returned to the host with every command.
module spi_cmd_ctrl #(
    parameter int TIMEOUT    = 64,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_spi_active,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_load,
    output logic                  o_reg_req,
    output logic                  o_reg_we,
    output logic [7:0]            o_reg_addr,
    output logic [DATA_WIDTH-1:0] o_reg_wdata,
    input  logic                  i_reg_ack,
    input  logic [DATA_WIDTH-1:0] i_reg_rdata,
    output logic [3:0]            o_status,
    input  logic                  i_status_clr,
    output logic                  o_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [DATA_WIDTH-1:0] TX_DRAIN   = 16'hFFFF;
    localparam logic [DATA_WIDTH-1:0] TX_TIMEOUT = 16'hDEAD;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_WAIT,
        ST_DATA,
        ST_DRAIN
    } state_t;

    state_t                state_q, state_d;
    logic [7:0]            addr_q, addr_d;
    logic [4:0]            remaining_q, remaining_d;
    logic                  write_q, write_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_load_q, tx_load_d;
    logic                  reg_req_q, reg_req_d;
    logic                  reg_we_q, reg_we_d;
    logic [DATA_WIDTH-1:0] reg_wdata_q, reg_wdata_d;
    logic [3:0]            status_q, status_d;
    logic                  busy_q, busy_d;
    logic                  active_q, active_d;
    logic                  abort_pend_q, abort_pend_d;

    logic       cs_rise;
    logic       cs_fall;
    logic       timeout_hit;
    logic       bus_done;
    logic [3:0] status_set;

    // State and output registers; reset drops any outstanding bus request at once.
    always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
        if (i_sys_rst) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            remaining_q  <= '0;
            write_q      <= 1'b0;
            timer_q      <= '0;
            tx_data_q    <= '0;
            tx_load_q    <= 1'b0;
            reg_req_q    <= 1'b0;
            reg_we_q     <= 1'b0;
            reg_wdata_q  <= '0;
            status_q     <= '0;
            busy_q       <= 1'b0;
            active_q     <= 1'b0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            write_q      <= write_d;
            timer_q      <= timer_d;
            tx_data_q    <= tx_data_d;
            tx_load_q    <= tx_load_d;
            reg_req_q    <= reg_req_d;
            reg_we_q     <= reg_we_d;
            reg_wdata_q  <= reg_wdata_d;
            status_q     <= status_d;
            busy_q       <= busy_d;
            active_q     <= active_d;
            abort_pend_q <= abort_pend_d;
        end
    end

    // Next-state, bus handshake, TX preload and status flag logic.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        remaining_d  = remaining_q;
        write_d      = write_q;
        tx_data_d    = tx_data_q;
        tx_load_d    = 1'b0;
        reg_req_d    = reg_req_q;
        reg_we_d     = reg_we_q;
        reg_wdata_d  = reg_wdata_q;
        abort_pend_d = abort_pend_q;
        status_set   = 4'b0000;
        active_d     = i_spi_active;

        cs_rise     = i_spi_active & ~active_q;
        cs_fall     = ~i_spi_active & active_q;
        // The wait counter runs only while a request is held, so it is zero
        // in the first cycle the request is visible on the bus.
        timeout_hit = reg_req_q && (timer_q == TW'(TIMEOUT - 1));
        bus_done    = reg_req_q && (i_reg_ack || timeout_hit);
        timer_d     = reg_req_q ? timer_q + TW'(1) : '0;

        // Words that arrive while a bus transaction is pending, or after the
        // frame's data phase is over, are dropped and flagged as overrun.
        if (i_rx_valid && (state_q == ST_RD_REQ || state_q == ST_RD_WAIT ||
                           state_q == ST_WR_WAIT || state_q == ST_DRAIN)) begin
            status_set[1] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                abort_pend_d = 1'b0;
                if (cs_rise) begin
                    tx_data_d = {12'h5A0, status_q};
                    tx_load_d = 1'b1;
                    state_d   = ST_CMD;
                end
            end

            ST_CMD: begin
                if (cs_fall) begin
                    state_d = ST_IDLE;
                end else if (i_rx_valid) begin
                    addr_d      = i_rx_data[7:0];
                    remaining_d = {1'b0, i_rx_data[11:8]} + 5'd1;
                    write_d     = i_rx_data[15];
                    if (i_rx_data[14:12] != 3'b000) begin
                        status_set[3] = 1'b1;
                        tx_data_d     = TX_DRAIN;
                        tx_load_d     = 1'b1;
                        state_d       = ST_DRAIN;
                    end else if (i_rx_data[15]) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d = ST_RD_REQ;
                    end
                end
            end

            ST_RD_REQ: begin
                if (cs_fall) begin
                    status_set[0] = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    reg_req_d = 1'b1;
                    reg_we_d  = 1'b0;
                    state_d   = ST_RD_WAIT;
                end
            end

            ST_RD_WAIT: begin
                // A CS drop here is remembered; the request still completes.
                if (cs_fall) begin
                    status_set[0] = 1'b1;
                    abort_pend_d  = 1'b1;
                end
                if (bus_done) begin
                    reg_req_d   = 1'b0;
                    addr_d      = addr_q + 8'd1;
                    remaining_d = remaining_q - 5'd1;
                    if (!i_reg_ack) begin
                        status_set[2] = 1'b1;
                    end
                    if (abort_pend_q || cs_fall) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_data_d = i_reg_ack ? i_reg_rdata : TX_TIMEOUT;
                        tx_load_d = 1'b1;
                        state_d   = ST_DATA;
                    end
                end
            end

            ST_WR_WAIT: begin
                if (cs_fall) begin
                    status_set[0] = 1'b1;
                    abort_pend_d  = 1'b1;
                end
                if (bus_done) begin
                    reg_req_d   = 1'b0;
                    addr_d      = addr_q + 8'd1;
                    remaining_d = remaining_q - 5'd1;
                    if (!i_reg_ack) begin
                        status_set[2] = 1'b1;
                    end
                    if (abort_pend_q || cs_fall) begin
                        state_d = ST_IDLE;
                    end else if (remaining_q == 5'd1) begin
                        tx_data_d = TX_DRAIN;
                        tx_load_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end

            ST_DATA: begin
                if (cs_fall) begin
                    status_set[0] = 1'b1;
                    state_d       = ST_IDLE;
                end else if (i_rx_valid) begin
                    if (write_q) begin
                        reg_req_d   = 1'b1;
                        reg_we_d    = 1'b1;
                        reg_wdata_d = i_rx_data;
                        state_d     = ST_WR_WAIT;
                    end else if (remaining_q != 5'd0) begin
                        state_d = ST_RD_REQ;
                    end else begin
                        tx_data_d = TX_DRAIN;
                        tx_load_d = 1'b1;
                        state_d   = ST_DRAIN;
                    end
                end
            end

            ST_DRAIN: begin
                if (cs_fall) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A flag raised in the same cycle as a clear survives the clear.
        status_d = (i_status_clr ? 4'b0000 : status_q) | status_set;
        busy_d   = (state_d != ST_IDLE);
    end

    assign o_tx_data   = tx_data_q;
    assign o_tx_load   = tx_load_q;
    assign o_reg_req   = reg_req_q;
    assign o_reg_we    = reg_we_q;
    assign o_reg_addr  = addr_q;
    assign o_reg_wdata = reg_wdata_q;
    assign o_status    = status_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Testbench for spi_cmd_ctrl: table of whole frames applied through a simple
// host model, a register-bus responder with a read bank, and hand-written
// sequences for abort, abort with an outstanding request, and async reset.
module tb_spi_cmd_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        spi_active;
    logic [15:0] tx_data;
    logic        tx_load;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_ack;
    logic [15:0] reg_rdata;
    logic [3:0]  status;
    logic        status_clr;
    logic        busy;

    spi_cmd_ctrl #(.TIMEOUT(64), .DATA_WIDTH(16)) dut (
        .i_sys_clk   (clk),
        .i_sys_rst   (rst),
        .i_rx_data   (rx_data),
        .i_rx_valid  (rx_valid),
        .i_spi_active(spi_active),
        .o_tx_data   (tx_data),
        .o_tx_load   (tx_load),
        .o_reg_req   (reg_req),
        .o_reg_we    (reg_we),
        .o_reg_addr  (reg_addr),
        .o_reg_wdata (reg_wdata),
        .i_reg_ack   (reg_ack),
        .i_reg_rdata (reg_rdata),
        .o_status    (status),
        .i_status_clr(status_clr),
        .o_busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Bus responder state and read bank
    logic [15:0] bank [256];
    bit          ack_en;
    int          ack_cnt = 0;

    // Monitor state
    logic [15:0] last_tx;
    logic        req_prev = 1'b0;
    int          run_cnt  = 0;
    int          last_run = 0;
    logic        lg_we    [64];
    logic [7:0]  lg_addr  [64];
    logic [15:0] lg_wdata [64];
    int          lg_n = 0;

    logic [3:0][15:0] miso_cap;
    logic             busy_mid;

    typedef struct {
        logic [15:0]      cmd;
        int               n;
        logic [3:0][15:0] d;
        int               gap;
        bit               ack;
        bit               clr;
        logic [3:0]       exp_status;
        int               exp_nbus;
        bit               exp_we;
        logic [3:0][7:0]  exp_addr;
        logic [3:0][15:0] exp_wdata;
        int               exp_nmiso;
        logic [3:0][15:0] exp_miso;
        int               exp_run;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(logic [15:0] cmd, int n, logic [63:0] d, int gap,
                                bit ack, bit clr, logic [3:0] st, int nbus, bit we,
                                logic [31:0] addr, logic [63:0] wd, int nm,
                                logic [63:0] miso, int run);
        vec_t v;
        v.cmd = cmd; v.n = n; v.d = d; v.gap = gap; v.ack = ack; v.clr = clr;
        v.exp_status = st; v.exp_nbus = nbus; v.exp_we = we; v.exp_addr = addr;
        v.exp_wdata = wd; v.exp_nmiso = nm; v.exp_miso = miso; v.exp_run = run;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Register bus: acknowledge on the second cycle of a held request.
    always @(negedge clk) begin
        reg_ack = 1'b0;
        if (reg_req && ack_en) begin
            ack_cnt++;
            if (ack_cnt == 2) begin
                reg_ack   = 1'b1;
                reg_rdata = bank[reg_addr];
            end
        end else begin
            ack_cnt = 0;
        end
    end

    // Monitor: latest TX preload, bus request log, request-high run length.
    always @(negedge clk) begin
        if (tx_load) last_tx = tx_data;
        if (reg_req && !req_prev) begin
            if (lg_n < 64) begin
                lg_we[lg_n]    = reg_we;
                lg_addr[lg_n]  = reg_addr;
                lg_wdata[lg_n] = reg_wdata;
            end
            $display("bus %s addr=%02h wdata=%04h", reg_we ? "WR" : "RD", reg_addr, reg_wdata);
            lg_n++;
        end
        if (reg_req) begin
            run_cnt++;
        end else begin
            if (run_cnt != 0) last_run = run_cnt;
            run_cnt = 0;
        end
        req_prev = reg_req;
    end

    task automatic pulse_clr();
        @(negedge clk);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
    endtask

    // Host model: CS high, command plus n data words spaced by gap cycles,
    // MISO word w is the TX word the core holds when word w is received.
    task automatic send_frame(logic [15:0] cmd, int n, logic [3:0][15:0] d, int gap);
        @(negedge clk);
        spi_active = 1'b1;
        for (int w = 0; w <= n; w++) begin
            repeat (gap) @(negedge clk);
            if (w == 0) busy_mid = busy;
            miso_cap[w] = last_tx;
            rx_data  = (w == 0) ? cmd : d[w-1];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
        end
        repeat (gap) @(negedge clk);
        spi_active = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_tx_data"},   32'(tx_data),   32'h0);
        chk({tag, "_tx_load"},   32'(tx_load),   32'h0);
        chk({tag, "_reg_req"},   32'(reg_req),   32'h0);
        chk({tag, "_reg_we"},    32'(reg_we),    32'h0);
        chk({tag, "_reg_addr"},  32'(reg_addr),  32'h0);
        chk({tag, "_reg_wdata"}, 32'(reg_wdata), 32'h0);
        chk({tag, "_status"},    32'(status),    32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
    endtask

    initial begin
        int base;
        rst        = 1'b1;
        rx_data    = '0;
        rx_valid   = 1'b0;
        spi_active = 1'b0;
        status_clr = 1'b0;
        reg_ack    = 1'b0;
        reg_rdata  = '0;
        ack_en     = 1'b1;
        last_tx    = '0;
        for (int i = 0; i < 256; i++) bank[i] = 16'(i * 3);
        bank[8'h20] = 16'hBEEF;
        bank[8'h21] = 16'hCAFE;

        //          cmd       n  data (word0 lowest)                          gap  ack clr status  nbus we addr          wdata                                       nmiso miso                                       run
        vecs[0] = mk(16'h8210, 3, {16'h0, 16'h3333, 16'h2222, 16'h1111},     20,  1,  0,  4'b0000, 3,  1, 32'h00121110, {16'h0, 16'h3333, 16'h2222, 16'h1111},     1, {16'h0, 16'h0, 16'h0, 16'h5A00},          0);
        vecs[1] = mk(16'h0120, 2, 64'h0,                                     20,  1,  0,  4'b0000, 2,  0, 32'h00002120, 64'h0,                                     3, {16'h0, 16'hCAFE, 16'hBEEF, 16'h5A00},    0);
        vecs[2] = mk(16'h81FF, 2, {16'h0, 16'h0, 16'hBBBB, 16'hAAAA},        20,  1,  0,  4'b0000, 2,  1, 32'h000000FF, {16'h0, 16'h0, 16'hBBBB, 16'hAAAA},        1, {16'h0, 16'h0, 16'h0, 16'h5A00},          0);
        vecs[3] = mk(16'h0030, 1, 64'h0,                                     100, 0,  0,  4'b0100, 1,  0, 32'h00000030, 64'h0,                                     2, {16'h0, 16'h0, 16'hDEAD, 16'h5A00},       64);
        vecs[4] = mk(16'h8040, 3, {16'h0, 16'h9ABC, 16'h5678, 16'h1234},     20,  1,  0,  4'b0110, 1,  1, 32'h00000040, {16'h0, 16'h0, 16'h0, 16'h1234},           1, {16'h0, 16'h0, 16'h0, 16'h5A04},          0);
        vecs[5] = mk(16'h1000, 0, 64'h0,                                     20,  1,  0,  4'b1110, 0,  0, 32'h0,        64'h0,                                     1, {16'h0, 16'h0, 16'h0, 16'h5A06},          0);
        vecs[6] = mk(16'h0021, 1, 64'h0,                                     20,  1,  1,  4'b0000, 1,  0, 32'h00000021, 64'h0,                                     2, {16'h0, 16'h0, 16'hCAFE, 16'h5A00},       0);

        // Reset state
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Table of whole frames
        for (int i = 0; i < 7; i++) begin
            ack_en = vecs[i].ack;
            if (vecs[i].clr) pulse_clr();
            base = lg_n;
            send_frame(vecs[i].cmd, vecs[i].n, vecs[i].d, vecs[i].gap);
            $display("frame %0d cmd=%04h words=%0d status=%04b bus=%0d last_tx=%04h",
                     i, vecs[i].cmd, vecs[i].n, status, lg_n - base, last_tx);
            chk($sformatf("v%0d_status", i), 32'(status), 32'(vecs[i].exp_status));
            chk($sformatf("v%0d_nbus", i), 32'(lg_n - base), 32'(vecs[i].exp_nbus));
            for (int k = 0; k < vecs[i].exp_nbus; k++) begin
                chk($sformatf("v%0d_bus%0d_addr", i, k), 32'(lg_addr[base+k]), 32'(vecs[i].exp_addr[k]));
                chk($sformatf("v%0d_bus%0d_we", i, k), 32'(lg_we[base+k]), 32'(vecs[i].exp_we));
                if (vecs[i].exp_we)
                    chk($sformatf("v%0d_bus%0d_wdata", i, k), 32'(lg_wdata[base+k]), 32'(vecs[i].exp_wdata[k]));
            end
            for (int k = 0; k < vecs[i].exp_nmiso; k++)
                chk($sformatf("v%0d_miso%0d", i, k), 32'(miso_cap[k]), 32'(vecs[i].exp_miso[k]));
            chk($sformatf("v%0d_drain_tx", i), 32'(last_tx), 32'hFFFF);
            chk($sformatf("v%0d_busy_mid", i), 32'(busy_mid), 32'h1);
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
            if (vecs[i].exp_run != 0)
                chk($sformatf("v%0d_req_cycles", i), 32'(last_run), 32'(vecs[i].exp_run));
        end

        // Status clear
        pulse_clr();
        @(negedge clk);
        chk("clr_status", 32'(status), 32'h0);

        // Abort: CS drops after 1 of 3 write words
        ack_en = 1'b1;
        base = lg_n;
        send_frame(16'h8250, 1, {16'h0, 16'h0, 16'h0, 16'h1111}, 20);
        $display("abort frame status=%04b bus=%0d", status, lg_n - base);
        chk("abort_status", 32'(status), 32'h1);
        chk("abort_nbus", 32'(lg_n - base), 32'h1);
        chk("abort_addr", 32'(lg_addr[base]), 32'h50);
        chk("abort_wdata", 32'(lg_wdata[base]), 32'h1111);
        chk("abort_no_drain_tx", 32'(last_tx), 32'h5A00);
        chk("abort_busy", 32'(busy), 32'h0);

        // Abort while a read request is outstanding: request must run to timeout
        pulse_clr();
        ack_en = 1'b0;
        @(negedge clk);
        spi_active = 1'b1;
        repeat (10) @(negedge clk);
        rx_data  = 16'h0060;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("pend_req_before", 32'(reg_req), 32'h1);
        spi_active = 1'b0;
        repeat (3) @(negedge clk);
        chk("pend_req_held", 32'(reg_req), 32'h1);
        chk("pend_busy_held", 32'(busy), 32'h1);
        repeat (80) @(negedge clk);
        $display("abort-with-request status=%04b req=%0b busy=%0b", status, reg_req, busy);
        chk("pend_req_done", 32'(reg_req), 32'h0);
        chk("pend_busy_done", 32'(busy), 32'h0);
        chk("pend_status", 32'(status), 32'h5);

        // Asynchronous reset in the middle of a read
        @(negedge clk);
        spi_active = 1'b1;
        repeat (10) @(negedge clk);
        rx_data  = 16'h0070;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mid_req", 32'(reg_req), 32'h1);
        chk("rst_mid_addr", 32'(reg_addr), 32'h70);
        #2;
        rst = 1'b1;
        #1;
        $display("async reset mid-read req=%0b status=%04b tx=%04h", reg_req, status, tx_data);
        chk_reset_outputs("async_rst");
        @(negedge clk);
        spi_active = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'h0);
        chk("post_rst_req", 32'(reg_req), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
